// File: rtl/pc_flush_arb_if.sv
// Handshake/bus bundle between the commit stage, CSR unit and the PC flush arbiter.
// master = commit/CSR/IFU side, slave = the arbiter.
interface pc_flush_arb_if #(
    parameter int PC_SIZE = 32,
    parameter int CAUSE_W = 5
);
    logic               cmt_vld;
    logic [PC_SIZE-1:0] cmt_pc;
    logic               cmt_rv32;
    logic               excp_req;
    logic [CAUSE_W-1:0] excp_cause;
    logic               alu_flush_req;
    logic [PC_SIZE-1:0] alu_flush_pc;
    logic               mret_req;
    logic [PC_SIZE-1:0] csr_mepc;
    logic [PC_SIZE-1:0] csr_mtvec;
    logic               csr_mie;
    logic               irq_req;
    logic [CAUSE_W-1:0] irq_cause;
    logic               flush_rdy;
    logic               flush_vld;
    logic [PC_SIZE-1:0] flush_pc;
    logic               commit_stall;
    logic               wbck_vld;
    logic [PC_SIZE-1:0] wbck_epc;
    logic [CAUSE_W:0]   wbck_cause;
    logic               irq_ack;
    logic               mie_clr;
    logic               mie_set;

    modport master (
        output cmt_vld, cmt_pc, cmt_rv32, excp_req, excp_cause, alu_flush_req, alu_flush_pc,
               mret_req, csr_mepc, csr_mtvec, csr_mie, irq_req, irq_cause, flush_rdy,
        input  flush_vld, flush_pc, commit_stall, wbck_vld, wbck_epc, wbck_cause,
               irq_ack, mie_clr, mie_set
    );

    modport slave (
        input  cmt_vld, cmt_pc, cmt_rv32, excp_req, excp_cause, alu_flush_req, alu_flush_pc,
               mret_req, csr_mepc, csr_mtvec, csr_mie, irq_req, irq_cause, flush_rdy,
        output flush_vld, flush_pc, commit_stall, wbck_vld, wbck_epc, wbck_cause,
               irq_ack, mie_clr, mie_set
    );
endinterface

// File: rtl/pc_flush_arb.sv
// Merges exception/interrupt/mret/jump redirects into one registered flush; decision at commit, outputs next cycle.
// The flush is held (commit stalled) until flush_rdy is sampled high, then the arbiter returns to IDLE.
module pc_flush_arb #(
    parameter int PC_SIZE = 32,
    parameter int CAUSE_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    pc_flush_arb_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state;
    logic               irq_pend;
    logic [PC_SIZE-1:0] base;
    logic [PC_SIZE-1:0] irq_vec;
    logic [PC_SIZE-1:0] seq_pc;
    logic [PC_SIZE-1:0] irq_epc;
    logic               take_irq;

    always_comb begin
        base     = {bus.csr_mtvec[PC_SIZE-1:2], 2'b00};
        irq_vec  = (bus.csr_mtvec[1:0] == 2'b01) ? base + PC_SIZE'({bus.irq_cause, 2'b00}) : base;
        seq_pc   = bus.cmt_pc + (bus.cmt_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));
        // An interrupt taken on a redirecting instruction must return to where that instruction was going.
        irq_epc  = bus.alu_flush_req ? bus.alu_flush_pc :
                   bus.mret_req      ? bus.csr_mepc     : seq_pc;
        take_irq = irq_pend & bus.csr_mie;
    end

    assign bus.commit_stall = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            irq_pend       <= 1'b0;
            bus.flush_vld  <= 1'b0;
            bus.flush_pc   <= '0;
            bus.wbck_vld   <= 1'b0;
            bus.wbck_epc   <= '0;
            bus.wbck_cause <= '0;
            bus.irq_ack    <= 1'b0;
            bus.mie_clr    <= 1'b0;
            bus.mie_set    <= 1'b0;
        end else begin
            bus.wbck_vld <= 1'b0;
            bus.irq_ack  <= 1'b0;
            bus.mie_clr  <= 1'b0;
            bus.mie_set  <= 1'b0;
            irq_pend     <= bus.irq_ack ? 1'b0 : (irq_pend | (bus.irq_req & bus.csr_mie));
            case (state)
                IDLE: begin
                    if (bus.cmt_vld) begin
                        if (bus.excp_req) begin
                            state          <= HOLD;
                            bus.flush_vld  <= 1'b1;
                            bus.flush_pc   <= base;
                            bus.wbck_vld   <= 1'b1;
                            bus.wbck_epc   <= bus.cmt_pc;
                            bus.wbck_cause <= {1'b0, bus.excp_cause};
                            bus.mie_clr    <= 1'b1;
                        end else if (take_irq) begin
                            state          <= HOLD;
                            bus.flush_vld  <= 1'b1;
                            bus.flush_pc   <= irq_vec;
                            bus.wbck_vld   <= 1'b1;
                            bus.wbck_epc   <= irq_epc;
                            bus.wbck_cause <= {1'b1, bus.irq_cause};
                            bus.irq_ack    <= 1'b1;
                            bus.mie_clr    <= 1'b1;
                        end else if (bus.mret_req) begin
                            state          <= HOLD;
                            bus.flush_vld  <= 1'b1;
                            bus.flush_pc   <= bus.csr_mepc;
                            bus.mie_set    <= 1'b1;
                        end else if (bus.alu_flush_req) begin
                            state          <= HOLD;
                            bus.flush_vld  <= 1'b1;
                            bus.flush_pc   <= bus.alu_flush_pc;
                        end
                    end
                end
                HOLD: begin
                    if (bus.flush_rdy) begin
                        state         <= IDLE;
                        bus.flush_vld <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_flush_arb.sv
// Bench for pc_flush_arb: directed vector table, hand-written multi-cycle sequences, randomized model check.
module tb_pc_flush_arb;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    pc_flush_arb_if #(.PC_SIZE(32), .CAUSE_W(5)) bus ();

    pc_flush_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] mtvec;  logic [31:0] pc;   bit rv32;  bit excp; logic [4:0] ecause;
        bit alu;             logic [31:0] alu_pc;          bit mret; logic [31:0] mepc;
        bit irq;             logic [4:0] icause;
        bit e_vld;           logic [31:0] e_pc; bit e_wb;  logic [31:0] e_epc; logic [5:0] e_cause;
        bit e_ack;           bit e_clr;         bit e_set;
    } vec_t;

    typedef struct {
        bit take; logic [31:0] pc; bit wb; logic [31:0] epc; logic [5:0] cause;
        bit ack;  bit clr;         bit set;
    } trap_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.cmt_vld = 1'b0; bus.excp_req = 1'b0; bus.alu_flush_req = 1'b0;
        bus.mret_req = 1'b0; bus.irq_req = 1'b0;
    endtask

    task automatic chk_pulses(input string tag, input bit wb, input bit ack, input bit clr, input bit set);
        chk({tag, "_wbck_vld"}, 32'(bus.wbck_vld), 32'(wb));
        chk({tag, "_irq_ack"},  32'(bus.irq_ack),  32'(ack));
        chk({tag, "_mie_clr"},  32'(bus.mie_clr),  32'(clr));
        chk({tag, "_mie_set"},  32'(bus.mie_set),  32'(set));
    endtask

    task automatic pulse_irq(input logic [4:0] cause);
        bus.irq_req = 1'b1; bus.irq_cause = cause; bus.cmt_vld = 1'b0;
        tick();
        bus.irq_req = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input bit rv32);
        bus.cmt_vld = 1'b1; bus.cmt_pc = pc; bus.cmt_rv32 = rv32;
        tick();
        quiet();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        bus.csr_mie = 1'b1; bus.flush_rdy = 1'b1;
        bus.csr_mtvec = v.mtvec; bus.csr_mepc = v.mepc;
        if (v.irq) pulse_irq(v.icause);
        bus.excp_req = v.excp; bus.excp_cause = v.ecause;
        bus.alu_flush_req = v.alu; bus.alu_flush_pc = v.alu_pc;
        bus.mret_req = v.mret; bus.irq_cause = v.icause;
        commit(v.pc, v.rv32);
        chk({tag, "_flush_vld"}, 32'(bus.flush_vld), 32'(v.e_vld));
        chk({tag, "_stall"}, 32'(bus.commit_stall), 32'(v.e_vld));
        if (v.e_vld) chk({tag, "_flush_pc"}, bus.flush_pc, v.e_pc);
        chk_pulses(tag, v.e_wb, v.e_ack, v.e_clr, v.e_set);
        if (v.e_wb) begin
            chk({tag, "_epc"}, bus.wbck_epc, v.e_epc);
            chk({tag, "_cause"}, 32'(bus.wbck_cause), 32'(v.e_cause));
        end
        tick();
        chk({tag, "_idle_vld"}, 32'(bus.flush_vld), 32'd0);
        chk({tag, "_idle_stall"}, 32'(bus.commit_stall), 32'd0);
        chk_pulses({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Trap selection written directly from the priority rules, on the current input values.
    function automatic trap_t classify(input bit pend);
        trap_t       t;
        logic [31:0] base;
        t = '{default: 0};
        base = bus.csr_mtvec & 32'hFFFF_FFFC;
        if (!bus.cmt_vld) return t;
        if (bus.excp_req) begin
            t.take = 1; t.pc = base; t.wb = 1; t.epc = bus.cmt_pc;
            t.cause = {1'b0, bus.excp_cause}; t.clr = 1;
        end else if (pend && bus.csr_mie) begin
            t.take = 1; t.wb = 1; t.ack = 1; t.clr = 1;
            t.pc = (bus.csr_mtvec[1:0] == 2'b01) ? base + 32'(bus.irq_cause) * 32'd4 : base;
            if (bus.alu_flush_req)  t.epc = bus.alu_flush_pc;
            else if (bus.mret_req)  t.epc = bus.csr_mepc;
            else                    t.epc = bus.cmt_pc + (bus.cmt_rv32 ? 32'd4 : 32'd2);
            t.cause = {1'b1, bus.irq_cause};
        end else if (bus.mret_req) begin
            t.take = 1; t.pc = bus.csr_mepc; t.set = 1;
        end else if (bus.alu_flush_req) begin
            t.take = 1; t.pc = bus.alu_flush_pc;
        end
        return t;
    endfunction

    vec_t        vecs[10];
    trap_t       tr;
    bit          m_busy, m_pend, m_ack;
    logic [31:0] m_pc;
    logic [31:0] held_pc;

    initial begin
        n_chk = 0; n_fail = 0;
        vecs[0] = '{32'h100, 32'h80, 1, 1, 5'd2, 0, 32'h0, 0, 32'h0, 0, 5'd0,
                    1, 32'h100, 1, 32'h80, 6'h02, 0, 1, 0};
        vecs[1] = '{32'h201, 32'h40, 0, 0, 5'd0, 0, 32'h0, 0, 32'h0, 1, 5'd7,
                    1, 32'h21C, 1, 32'h42, 6'h27, 1, 1, 0};
        vecs[2] = '{32'h100, 32'h60, 1, 0, 5'd0, 1, 32'h300, 0, 32'h0, 1, 5'd3,
                    1, 32'h100, 1, 32'h300, 6'h23, 1, 1, 0};
        vecs[3] = '{32'h100, 32'h70, 1, 0, 5'd0, 0, 32'h0, 1, 32'h1234, 0, 5'd0,
                    1, 32'h1234, 0, 32'h0, 6'h00, 0, 0, 1};
        vecs[4] = '{32'h100, 32'h74, 1, 0, 5'd0, 1, 32'h500, 0, 32'h0, 0, 5'd0,
                    1, 32'h500, 0, 32'h0, 6'h00, 0, 0, 0};
        vecs[5] = '{32'h100, 32'h78, 1, 0, 5'd0, 0, 32'h0, 0, 32'h0, 0, 5'd0,
                    0, 32'h0, 0, 32'h0, 6'h00, 0, 0, 0};
        vecs[6] = '{32'h401, 32'h90, 1, 0, 5'd0, 0, 32'h0, 1, 32'h888, 1, 5'd1,
                    1, 32'h404, 1, 32'h888, 6'h21, 1, 1, 0};
        vecs[7] = '{32'h203, 32'hA0, 1, 1, 5'd31, 1, 32'h600, 1, 32'h700, 0, 5'd0,
                    1, 32'h200, 1, 32'hA0, 6'h1F, 0, 1, 0};
        vecs[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 1, 0, 5'd0, 0, 32'h0, 0, 32'h0, 1, 5'd2,
                    1, 32'h4, 1, 32'h2, 6'h22, 1, 1, 0};
        vecs[9] = '{32'h100, 32'hB0, 0, 0, 5'd0, 1, 32'h900, 1, 32'h444, 0, 5'd0,
                    1, 32'h444, 0, 32'h0, 6'h00, 0, 0, 1};

        quiet();
        bus.cmt_pc = '0; bus.cmt_rv32 = 1'b1; bus.excp_cause = '0; bus.alu_flush_pc = '0;
        bus.csr_mepc = '0; bus.csr_mtvec = 32'h100; bus.csr_mie = 1'b1; bus.irq_cause = '0;
        bus.flush_rdy = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_flush_vld", 32'(bus.flush_vld), 32'd0);
        chk("rst_flush_pc", bus.flush_pc, 32'd0);
        chk("rst_stall", 32'(bus.commit_stall), 32'd0);
        chk("rst_epc", bus.wbck_epc, 32'd0);
        chk("rst_cause", 32'(bus.wbck_cause), 32'd0);
        chk_pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Backpressure: flush held for three cycles, pulses only once, HOLD ignores commits.
        bus.csr_mtvec = 32'h100; bus.flush_rdy = 1'b0;
        bus.excp_req = 1'b1; bus.excp_cause = 5'd5;
        commit(32'hC0, 1'b1);
        chk("bp_first_wbck", 32'(bus.wbck_vld), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_vld", 32'(bus.flush_vld), 32'd1);
            chk("bp_pc", bus.flush_pc, 32'h100);
            chk("bp_stall", 32'(bus.commit_stall), 32'd1);
            if (k > 0) chk_pulses("bp_hold", 1'b0, 1'b0, 1'b0, 1'b0);
            bus.alu_flush_req = 1'b1; bus.alu_flush_pc = 32'h777;
            commit(32'hC4, 1'b1);
        end
        chk("bp_still_pc", bus.flush_pc, 32'h100);
        chk_pulses("bp_last", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.flush_rdy = 1'b1;
        tick();
        chk("bp_release_vld", 32'(bus.flush_vld), 32'd0);
        chk("bp_release_stall", 32'(bus.commit_stall), 32'd0);

        // Interrupt latched while nothing commits, taken at the next commit boundary.
        pulse_irq(5'd9);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("lat_no_flush", 32'(bus.flush_vld), 32'd0);
            chk("lat_no_ack", 32'(bus.irq_ack), 32'd0);
        end
        commit(32'h50, 1'b1);
        chk("lat_ack", 32'(bus.irq_ack), 32'd1);
        chk("lat_epc", bus.wbck_epc, 32'h54);
        chk("lat_cause", 32'(bus.wbck_cause), 32'h29);
        tick();

        // Interrupt seen with mie=0 never becomes pending.
        bus.csr_mie = 1'b0;
        pulse_irq(5'd4);
        bus.csr_mie = 1'b1;
        bus.alu_flush_req = 1'b1; bus.alu_flush_pc = 32'h500;
        commit(32'h58, 1'b1);
        chk("mie0_pc", bus.flush_pc, 32'h500);
        chk("mie0_ack", 32'(bus.irq_ack), 32'd0);
        chk("mie0_wbck", 32'(bus.wbck_vld), 32'd0);
        tick();

        // Exception beats a pending interrupt; the interrupt follows at the next commit.
        pulse_irq(5'd11);
        bus.excp_req = 1'b1; bus.excp_cause = 5'd4;
        commit(32'h60, 1'b1);
        chk("ex1_cause", 32'(bus.wbck_cause), 32'h04);
        chk("ex1_ack", 32'(bus.irq_ack), 32'd0);
        tick();
        chk("ex1_done", 32'(bus.flush_vld), 32'd0);
        bus.alu_flush_req = 1'b1; bus.alu_flush_pc = 32'h300;
        commit(32'h100, 1'b1);
        chk("ex2_ack", 32'(bus.irq_ack), 32'd1);
        chk("ex2_pc", bus.flush_pc, 32'h100);
        chk("ex2_epc", bus.wbck_epc, 32'h300);
        chk("ex2_cause", 32'(bus.wbck_cause), 32'h2B);
        tick();

        // Reset while a flush is outstanding.
        bus.flush_rdy = 1'b0; bus.mret_req = 1'b1; bus.csr_mepc = 32'h4444;
        commit(32'h70, 1'b1);
        chk("rh_vld", 32'(bus.flush_vld), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rh_drop_vld", 32'(bus.flush_vld), 32'd0);
        chk("rh_drop_stall", 32'(bus.commit_stall), 32'd0);
        chk_pulses("rh_drop", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rh_idle", 32'(bus.flush_vld), 32'd0);

        // Randomized traffic against the reference model.
        m_busy = 0; m_pend = 0; m_ack = 0; m_pc = '0;
        for (int c = 0; c < 3000; c++) begin
            bus.cmt_vld       = 1'($urandom_range(0, 1));
            bus.cmt_pc        = $urandom();
            bus.cmt_rv32      = 1'($urandom_range(0, 1));
            bus.excp_req      = ($urandom_range(0, 7) == 0);
            bus.excp_cause    = 5'($urandom());
            bus.alu_flush_req = ($urandom_range(0, 2) == 0);
            bus.alu_flush_pc  = $urandom();
            bus.mret_req      = ($urandom_range(0, 5) == 0);
            bus.csr_mepc      = $urandom();
            bus.csr_mtvec     = $urandom();
            bus.csr_mie       = ($urandom_range(0, 3) != 0);
            bus.irq_req       = ($urandom_range(0, 7) == 0);
            bus.irq_cause     = 5'($urandom());
            bus.flush_rdy     = 1'($urandom_range(0, 1));
            tr = classify(m_pend);
            if (m_busy) begin
                if (bus.flush_rdy) m_busy = 0;
                tr = '{default: 0};
            end else if (tr.take) begin
                m_busy = 1;
                m_pc = tr.pc;
            end
            m_pend = m_ack ? 1'b0 : (m_pend | (bus.irq_req & bus.csr_mie));
            m_ack = tr.ack;
            held_pc = m_pc;
            tick();
            chk("rnd_vld", 32'(bus.flush_vld), 32'(m_busy));
            chk("rnd_stall", 32'(bus.commit_stall), 32'(m_busy));
            if (m_busy) chk("rnd_pc", bus.flush_pc, held_pc);
            chk_pulses("rnd", tr.wb, tr.ack, tr.clr, tr.set);
            if (tr.wb) begin
                chk("rnd_epc", bus.wbck_epc, tr.epc);
                chk("rnd_cause", 32'(bus.wbck_cause), 32'(tr.cause));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
